// File: rtl/uart_apb_sequencer.sv
// uart_apb_sequencer: two-requester round-robin APB master for a UART slave.
// Optional ACCESS timeout when UART_APB_SEQ_TIMEOUT_EN is defined.
`default_nettype none

module uart_apb_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        pclk,
  input  logic        PRESETn,
  input  logic [1:0]  req_valid,
  input  logic [1:0]  req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [1:0]  req_ready,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] PADDR,
  output logic [31:0] PWDATA,
  output logic        PWRITE,
  output logic [3:0]  PSTRB,
  output logic        PSELx,
  output logic        PENABLE,
  input  logic [31:0] PRDATA,
  input  logic        PREADY
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t state, state_next;
  logic   grant;        // doubles as the round-robin "last granted" pointer
  logic   grant_next;
  logic   any_valid;
  logic   accept;
  logic   access_end;
  logic   timed_out;

  // Elaboration-time guard: the range check only consumes the parameter.
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_timeout_out_of_range
  end

  assign any_valid  = |req_valid;
  assign grant_next = (req_valid == 2'b11) ? ~grant : req_valid[1];
  assign accept     = (state == IDLE) && any_valid;
  assign access_end = (state == ACCESS) && (PREADY || timed_out);

`ifdef UART_APB_SEQ_TIMEOUT_EN
  logic [15:0] access_cnt;
  logic        err_flag;

  assign timed_out = (state == ACCESS) && !PREADY &&
                     (access_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pclk or posedge PRESETn) begin
    if (PRESETn) begin
      access_cnt <= '0;
      err_flag   <= 1'b0;
    end else begin
      access_cnt <= (state == ACCESS) ? access_cnt + 16'd1 : 16'd0;
      if (access_end) err_flag <= !PREADY;
    end
  end

  assign rsp_err = rsp_valid && err_flag;
`else
  assign timed_out = 1'b0;
  assign rsp_err   = 1'b0;
`endif

  always_comb begin
    state_next = state;
    req_ready  = 2'b00;
    case (state)
      IDLE: begin
        if (any_valid) begin
          state_next = SETUP;
          // Reset forces IDLE, so mask the grant pulse while reset is held.
          if (!PRESETn) req_ready = grant_next ? 2'b10 : 2'b01;
        end
      end
      SETUP:   state_next = ACCESS;
      ACCESS:  if (PREADY || timed_out) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge PRESETn) begin
    if (PRESETn) begin
      state     <= IDLE;
      grant     <= 1'b1;
      PADDR     <= '0;
      PWDATA    <= '0;
      PWRITE    <= 1'b0;
      PSTRB     <= 4'b0000;
      rsp_rdata <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        grant  <= grant_next;
        PADDR  <= grant_next ? req_addr[63:32]  : req_addr[31:0];
        PWDATA <= grant_next ? req_wdata[63:32] : req_wdata[31:0];
        PWRITE <= req_write[grant_next];
        PSTRB  <= req_write[grant_next] ? 4'b0001 : 4'b0000;
      end
      if (access_end) rsp_rdata <= (PREADY && !PWRITE) ? PRDATA : 32'd0;
    end
  end

  assign PSELx     = (state == SETUP) || (state == ACCESS);
  assign PENABLE   = (state == ACCESS);
  assign rsp_valid = (state == RESP);
  assign rsp_id    = rsp_valid && grant;

endmodule

`default_nettype wire

// File: tb/tb_uart_apb_sequencer.sv
// ============================================================================
// Module      : tb_uart_apb_sequencer
// Description : Directed self-checking bench for uart_apb_sequencer.
// Revision    : 1.1
// ============================================================================
`default_nettype none

module tb_uart_apb_sequencer;

    localparam int C_TMO = 8;

    logic        pclk = 1'b0;
    logic        PRESETn;
    logic [1:0]  req_valid, req_write, req_ready;
    logic [63:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_id, rsp_err;
    logic [31:0] rsp_rdata, PADDR, PWDATA, PRDATA;
    logic        PWRITE, PSELx, PENABLE, PREADY;
    logic [3:0]  PSTRB;

    int n_checks = 0;
    int n_fail   = 0;
    int hold;

    uart_apb_sequencer #(.TIMEOUT_CYCLES(C_TMO)) dut (
        .pclk(pclk), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSTRB(PSTRB),
        .PSELx(PSELx), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        PRESETn = 1'b1; req_valid = 2'b00; req_write = 2'b00;
        req_addr = '0; req_wdata = '0; PRDATA = '0; PREADY = 1'b0;
        tick(); tick();
        n_checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_err, PSELx, PENABLE, PWRITE, PSTRB, PADDR, PWDATA, rsp_rdata}
            !== {2'b00, 3'b000, 2'b00, 1'b0, 4'b0000, 32'd0, 32'd0, 32'd0}) begin
            n_fail++; $error("FAIL reset_outputs");
        end
        PRESETn = 1'b0;
        tick();

        req_valid = 2'b01; req_write = 2'b01;
        req_addr = {32'h0, 32'h10}; req_wdata = {32'h0, 32'hA5}; PREADY = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++; $error("FAIL wr_ready_T: observed %0h", req_ready);
        end
        tick();
        req_valid = 2'b00;
        #1;
        n_checks++;
        if ({PSELx, PENABLE, PSTRB, PWRITE, req_ready} !== {2'b10, 4'b0001, 1'b1, 2'b00}) begin
            n_fail++; $error("FAIL wr_setup_T1");
        end
        n_checks++;
        if ({PADDR, PWDATA} !== {32'h10, 32'hA5}) begin
            n_fail++; $error("FAIL wr_addr_data");
        end
        tick();
        n_checks++;
        if ({PSELx, PENABLE, rsp_valid} !== 3'b110) begin
            n_fail++; $error("FAIL wr_access_T2");
        end
        tick();
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_err, PSELx, PENABLE} !== 5'b10000) begin
            n_fail++; $error("FAIL wr_resp_T3");
        end
        n_checks++;
        if (rsp_rdata !== 32'd0) begin
            n_fail++; $error("FAIL wr_rdata_zero: observed %0h", rsp_rdata);
        end
        tick();
        n_checks++;
        if ({rsp_valid, PADDR, PSTRB} !== {1'b0, 32'h10, 4'b0001}) begin
            n_fail++; $error("FAIL wr_idle_hold");
        end

        PRESETn = 1'b1;
        tick();
        PRESETn = 1'b0;

        req_valid = 2'b11; req_write = 2'b00;
        req_addr = {32'h200, 32'h100}; PRDATA = 32'h1234_5678; PREADY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            n_checks++;
            if (req_ready !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                n_fail++; $error("FAIL rr_ready k=%0d: observed %0h", k, req_ready);
            end
            tick(); tick(); tick();
            n_checks++;
            if ({rsp_valid, rsp_id, PSTRB} !== {1'b1, k[0], 4'b0000}) begin
                n_fail++; $error("FAIL rr_resp k=%0d", k);
            end
            n_checks++;
            if ({PADDR, rsp_rdata} !== {((k % 2 == 0) ? 32'h100 : 32'h200), 32'h1234_5678}) begin
                n_fail++; $error("FAIL rr_paddr_rdata k=%0d", k);
            end
            tick();
        end
        req_valid = 2'b00;
        tick();

        req_valid = 2'b10; req_write = 2'b00;
        req_addr = {32'hDEAD_BEE0, 32'h0}; PREADY = 1'b0; PRDATA = 32'h0;
        #1;
        n_checks++;
        if (req_ready !== 2'b10) begin
            n_fail++; $error("FAIL wait_ready: observed %0h", req_ready);
        end
        tick();
        req_valid = 2'b00;
        tick();
        hold = 0;
        for (int i = 0; i < 5; i++) begin
            if (PSELx && PENABLE && PADDR == 32'hDEAD_BEE0 && !rsp_valid) hold++;
            tick();
        end
        n_checks++;
        if (hold !== 5) begin
            n_fail++; $error("FAIL wait_access_held: observed %0d", hold);
        end
        PREADY = 1'b1; PRDATA = 32'h0000_005A;
        #1;
        n_checks++;
        if ({PSELx, PENABLE} !== 2'b11) begin
            n_fail++; $error("FAIL wait_last_access");
        end
        tick();
        PREADY = 1'b0; PRDATA = 32'hFFFF_FFFF;
        #1;
        n_checks++;
        if ({rsp_valid, rsp_id, rsp_err, PADDR} !== {3'b110, 32'hDEAD_BEE0}) begin
            n_fail++; $error("FAIL wait_resp");
        end
        n_checks++;
        if (rsp_rdata !== 32'h5A) begin
            n_fail++; $error("FAIL wait_rdata: observed %0h", rsp_rdata);
        end
        tick();
        n_checks++;
        if ({rsp_valid, rsp_rdata} !== {1'b0, 32'h5A}) begin
            n_fail++; $error("FAIL wait_rdata_hold");
        end

        req_write = 2'b00; req_addr = {32'h0, 32'h40}; PREADY = 1'b0;
`ifdef UART_APB_SEQ_TIMEOUT_EN
        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        tick();
        repeat (C_TMO - 1) tick();
        n_checks++;
        if ({PSELx, PENABLE} !== 2'b11) begin
            n_fail++; $error("FAIL tmo_last_access");
        end
        tick();
        n_checks++;
        if ({rsp_valid, rsp_err, PSELx, PENABLE} !== 4'b1100) begin
            n_fail++; $error("FAIL tmo_resp");
        end
        n_checks++;
        if (rsp_rdata !== 32'd0) begin
            n_fail++; $error("FAIL tmo_rdata: observed %0h", rsp_rdata);
        end
        tick();

        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        tick();
        repeat (C_TMO - 1) tick();
        PREADY = 1'b1; PRDATA = 32'h77;
        tick();
        PREADY = 1'b0;
        #1;
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'h77}) begin
            n_fail++; $error("FAIL tmo_boundary_ok");
        end
        tick();

        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        tick();
`else
        req_valid = 2'b01;
        #1;
        tick();
        req_valid = 2'b00;
        tick();
        hold = 0;
        for (int i = 0; i < 100; i++) begin
            if (PSELx && PENABLE && !rsp_valid) hold++;
            tick();
        end
        n_checks++;
        if (hold !== 100) begin
            n_fail++; $error("FAIL no_tmo_hold: observed %0d", hold);
        end
`endif

        n_checks++;
        if ({PSELx, PENABLE} !== 2'b11) begin
            n_fail++; $error("FAIL pre_reset_access");
        end
        req_valid = 2'b11; PREADY = 1'b1;
        PRESETn = 1'b1;
        #1;
        n_checks++;
        if ({PSELx, PENABLE, rsp_valid, req_ready} !== 5'b00000) begin
            n_fail++; $error("FAIL rst_immediate");
        end
        tick();
        n_checks++;
        if ({PSELx, PENABLE, rsp_valid, req_ready} !== 5'b00000) begin
            n_fail++; $error("FAIL rst_no_resp");
        end
        PRESETn = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++; $error("FAIL rst_tie_req0: observed %0h", req_ready);
        end
        tick();
        req_valid = 2'b00;
        tick(); tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
